boot_loader_ctrl: RTL and testbench

Sequencing controller for the UART program-load path. It consumes the byte stream from the UART receiver and frames it as a size header, a big-endian word payload and a checksum. It drives the instruction-memory write port word by word, then releases the CPU, or latches an error on a bad checksum or an inter-byte timeout. It sits between the UART receiver and the instruction memory, and owns `cpu_enable`.

---
 rtl/boot_loader_pkg.sv | 17 +
 rtl/boot_idle_timer.sv | 33 +++
 rtl/boot_loader_ctrl.sv | 125 ++++++++++++
 tb/tb_boot_loader_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the UART program-load controller.
// State encoding, frame-format constants and default timeout.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        WAIT_SIZE = 3'd0,
        RECV_WORD = 3'd1,
        WAIT_CSUM = 3'd2,
        DONE      = 3'd3,
        ERROR     = 3'd4
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 2700000;
    localparam int unsigned BYTES_PER_WORD     = 4;
    localparam logic [1:0]  LAST_BYTE_IDX      = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/boot_idle_timer.sv
// Inter-byte idle counter for the program-load path.
// Flags expiry on the last idle cycle before the frame is abandoned.
module boot_idle_timer
    import boot_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expired = enable && !clear && (cnt == LAST);

    // Count idle cycles while enabled; a byte or a disabled state restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Frames the UART byte stream into size, big-endian words and checksum,
// writes instruction memory word by word and releases the CPU.
module boot_loader_ctrl
    import boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_enable,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   size_q;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [ADDR_WIDTH:0]   word_inc;
    logic [1:0]            byte_idx;
    logic [7:0]            xor_q;
    logic [23:0]           asm_q;
    logic                  last_byte;
    logic                  timing;
    logic                  expired;

    assign word_inc     = word_idx + ONE;
    assign last_byte    = (byte_idx == LAST_BYTE_IDX);
    assign timing       = (state == RECV_WORD) || (state == WAIT_CSUM);
    assign words_loaded = word_idx;

    boot_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (timing),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_SIZE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: header, payload, checksum, then a sticky end state.
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_SIZE: begin
                if (rx_valid) begin
                    state_nxt = (rx_byte == 8'd0) ? WAIT_CSUM : RECV_WORD;
                end
            end
            RECV_WORD: begin
                if (rx_valid && last_byte && (word_inc == size_q)) begin
                    state_nxt = WAIT_CSUM;
                end else if (expired) begin
                    state_nxt = ERROR;
                end
            end
            WAIT_CSUM: begin
                if (rx_valid) begin
                    state_nxt = (rx_byte == xor_q) ? DONE : ERROR;
                end else if (expired) begin
                    state_nxt = ERROR;
                end
            end
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = ERROR;
        endcase
    end

    // Byte assembly, checksum accumulation and registered memory/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q     <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            xor_q      <= '0;
            asm_q      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_enable <= 1'b0;
            load_error <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            cpu_enable <= (state_nxt == DONE);
            load_error <= (state_nxt == ERROR);
            if (rx_valid && (state == WAIT_SIZE)) begin
                size_q   <= (ADDR_WIDTH + 1)'(rx_byte);
                word_idx <= '0;
                byte_idx <= '0;
                xor_q    <= '0;
            end
            if (rx_valid && (state == RECV_WORD)) begin
                asm_q    <= {asm_q[15:0], rx_byte};
                xor_q    <= xor_q ^ rx_byte;
                byte_idx <= byte_idx + 2'd1;
                if (last_byte) begin
                    mem_wdata <= {asm_q, rx_byte};
                    mem_addr  <= word_idx[ADDR_WIDTH-1:0];
                    mem_we    <= 1'b1;
                    word_idx  <= word_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: directed and random frames,
// timeout boundary, back-to-back max frame and mid-frame reset.
module tb_boot_loader_ctrl;

    localparam int AW = 8;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_enable;
    logic          load_error;
    logic [AW:0]   words_loaded;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [AW:0]   wl;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_we = 1'b0;

    boot_loader_ctrl #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_enable  (cpu_enable),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                check("we_single_cycle", 64'(prev_we), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: addr %0h data %0h, none expected",
                             mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("we_addr", 64'(mem_addr), 64'(e.addr));
                    check("we_data", 64'(mem_wdata), 64'(e.data));
                    check("we_words_loaded", 64'(words_loaded), 64'(e.wl));
                end
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_cpu_enable"}, 64'(cpu_enable), 64'd0);
        check({tag, "_load_error"}, 64'(load_error), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_byte  = $urandom_range(255, 0);
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends payload words MSB first; returns XOR of all payload bytes.
    task automatic send_words(input logic [31:0] words[$], input int gap_max,
                              output logic [7:0] x);
        x = 8'd0;
        for (int i = 0; i < words.size(); i++) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] w;
                logic [7:0]  by;
                w  = words[i];
                by = w[31 - 8*b -: 8];
                x  = x ^ by;
                if (b == 3) begin
                    exp_q.push_back('{addr: AW'(i), data: w, wl: (AW+1)'(i+1)});
                end
                send_byte(by, $urandom_range(gap_max, 0));
            end
        end
    endtask

    task automatic send_frame(input string tag, input logic [31:0] words[$],
                              input logic [7:0] delta, input int gap_max);
        logic [7:0] x;
        bit         bad;
        bad = (delta != 8'd0);
        send_byte(8'(words.size()), $urandom_range(gap_max, 0));
        send_words(words, gap_max, x);
        send_byte(x + delta, 1);
        check({tag, "_cpu_enable"}, 64'(cpu_enable), 64'(!bad));
        check({tag, "_load_error"}, 64'(load_error), 64'(bad));
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(words.size()));
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < 3; k++) send_byte($urandom_range(255, 0), 0);
        check({tag, "_cpu_enable_sticky"}, 64'(cpu_enable), 64'(!bad));
        check({tag, "_load_error_sticky"}, 64'(load_error), 64'(bad));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wq[$];
        logic [7:0]  x;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
        #3;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        wq = '{32'h0000_0013, 32'hDEAD_BEEF};
        send_frame("good2", wq, 8'd0, 0);

        do_reset();
        send_frame("badcsum", wq, 8'd1, 1);

        do_reset();
        wq.delete();
        send_frame("size0", wq, 8'd0, 0);

        do_reset();
        send_byte(8'd1, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, T - 1);
        check("timeout_before_expiry", 64'(load_error), 64'd0);
        @(posedge clk);
        #1;
        check("timeout_error", 64'(load_error), 64'd1);
        check("timeout_cpu_enable", 64'(cpu_enable), 64'd0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        check("timeout_words_loaded", 64'(words_loaded), 64'd0);

        do_reset();
        send_byte(8'd1, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, T - 1);
        check("expiry_accept_no_error", 64'(load_error), 64'd0);
        exp_q.push_back('{addr: AW'(0), data: 32'h1122_3344, wl: (AW+1)'(1)});
        send_byte(8'h33, T - 1);
        send_byte(8'h44, 0);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1);
        check("expiry_accept_cpu_enable", 64'(cpu_enable), 64'd1);
        check("expiry_accept_pending", 64'(exp_q.size()), 64'd0);

        for (int f = 0; f < 8; f++) begin
            int n;
            do_reset();
            wq.delete();
            n = $urandom_range(20, 1);
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            send_frame("random", wq,
                       ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0,
                       3);
        end

        do_reset();
        wq.delete();
        for (int i = 0; i < 255; i++) wq.push_back($urandom);
        send_frame("size255", wq, 8'd0, 0);

        do_reset();
        wq = '{32'hCAFE_0001, 32'h1234_5678};
        send_byte(8'd3, 0);
        send_words(wq, 0, x);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hEF, 0);
        check("midframe_loaded_before_rst", 64'(words_loaded), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        wq = '{32'h0BAD_F00D};
        send_frame("after_rst", wq, 8'd0, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
